// File: rtl/polyphase_decim_fir.sv
// polyphase_decim_fir: M:1 decimating FIR with programmable taps and one time-multiplexed MAC
module polyphase_decim_fir #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int N         = 16,
  parameter int M         = 2,
  parameter int OUT_SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic signed [DATA_W-1:0]  data_in,
  input  logic                      coef_wr,
  input  logic [$clog2(N)-1:0]      coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  input  logic                      overrun_clr,
  output logic                      valid_out,
  output logic signed [DATA_W-1:0]  data_out,
  output logic                      busy,
  output logic                      overrun
);
  localparam int AW = DATA_W + COEF_W + $clog2(N);
  localparam int PW = $clog2(M);
  localparam int TW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam logic signed [AW:0] HALF = (AW + 1)'(1) << (OUT_SHIFT - 1);
  localparam logic signed [AW:0] MAXV = (AW + 1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [AW:0] MINV = -MAXV - (AW + 1)'(1);
  logic signed [DATA_W-1:0] h [N];
  logic signed [DATA_W-1:0] s [N];
  logic signed [COEF_W-1:0] c [N];
  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     prod;
  logic signed [AW:0]       rnd;
  logic signed [AW:0]       shf;
  logic signed [DATA_W-1:0] sat;
  logic [PW-1:0]            phase;
  logic [TW-1:0]            tap;
  logic [IW-1:0]            idx;
  logic                     dec_event;
  assign dec_event = valid_in && phase == PW'(M - 1);
  assign idx  = tap[IW-1:0];
  assign prod = s[idx] * c[idx];
  // round-half-up then arithmetic shift, clamped to the output range
  assign rnd = {acc[AW-1], acc} + HALF;
  assign shf = rnd >>> OUT_SHIFT;
  assign sat = shf > MAXV ? MAXV[DATA_W-1:0] : shf < MINV ? MINV[DATA_W-1:0] : shf[DATA_W-1:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        h[k] <= '0;
        s[k] <= '0;
        c[k] <= '0;
      end
      acc       <= '0;
      phase     <= '0;
      tap       <= '0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      overrun   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (coef_wr && {1'b0, coef_addr} < (IW + 1)'(N)) c[coef_addr] <= coef_data;
      if (valid_in) begin
        h[0] <= data_in;
        for (int k = 1; k < N; k++) h[k] <= h[k-1];
        phase <= phase == PW'(M - 1) ? '0 : phase + PW'(1);
      end
      if (dec_event && !busy) begin
        s[0] <= data_in;
        for (int k = 1; k < N; k++) s[k] <= h[k-1];
        busy <= 1'b1;
        tap  <= '0;
      end else if (busy) begin
        if (tap == TW'(N)) begin
          data_out  <= sat;
          valid_out <= 1'b1;
          busy      <= 1'b0;
        end else begin
          acc <= tap == '0 ? prod : acc + prod;
          tap <= tap + TW'(1);
        end
      end
      if (overrun_clr) overrun <= 1'b0;
      if (dec_event && busy) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_polyphase_decim_fir.sv
// tb_polyphase_decim_fir: scoreboard bench with a behavioural FIR model and table-driven vectors
module tb_polyphase_decim_fir;
  localparam int N = 16;
  localparam int M = 2;
  localparam int SH = 15;
  logic clk = 0;
  logic reset = 1;
  logic valid_in = 0;
  logic signed [15:0] data_in = 0;
  logic coef_wr = 0;
  logic [3:0] coef_addr = 0;
  logic signed [15:0] coef_data = 0;
  logic overrun_clr = 0;
  logic valid_out;
  logic signed [15:0] data_out;
  logic busy;
  logic overrun;

  polyphase_decim_fir #(.DATA_W(16), .COEF_W(16), .N(N), .M(M), .OUT_SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .overrun_clr(overrun_clr), .valid_out(valid_out), .data_out(data_out),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int y; int cyc; } exp_t;
  typedef struct { string name; int c0; int crest; int x; int exp_y; } vec_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int nout = 0;
  int last_out = 0;
  int outs [64];
  int hm [N];
  int cm [N];
  int ph = 0;
  int la = -1000;

  task automatic chk(input string name, input longint act, input longint exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int model_y();
    longint a = 0;
    for (int k = 0; k < N; k++) a += longint'(hm[k]) * longint'(cm[k]);
    a = (a + (longint'(1) <<< (SH - 1))) >>> SH;
    return a > 32767 ? 32767 : a < -32768 ? -32768 : int'(a);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      hm[k] = 0;
      cm[k] = 0;
    end
    ph = 0;
    la = -1000;
    sbq.delete();
  endtask

  task automatic send(input int x, input bit clr);
    int ev;
    exp_t e;
    ev = cyc + 1;
    valid_in = 1;
    data_in = 16'(x);
    overrun_clr = clr;
    for (int k = N - 1; k > 0; k--) hm[k] = hm[k-1];
    hm[0] = x;
    if (ph == M - 1 && ev - la >= N + 2) begin
      la = ev;
      e.y = model_y();
      e.cyc = ev;
      sbq.push_back(e);
    end
    ph = (ph == M - 1) ? 0 : ph + 1;
    @(negedge clk);
    valid_in = 0;
    overrun_clr = 0;
  endtask

  task automatic wr_coef(input int a, input int v);
    coef_wr = 1;
    coef_addr = 4'(a);
    coef_data = 16'(v);
    cm[a] = v;
    @(negedge clk);
    coef_wr = 0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400 && (sbq.size() > 0 || busy); i++) @(negedge clk);
    chk("drain", sbq.size(), 0);
  endtask

  task automatic impulse(input int gap);
    nout = 0;
    send(32, 0);
    repeat (gap) @(negedge clk);
    for (int i = 0; i < 31; i++) begin
      send(0, 0);
      repeat (gap) @(negedge clk);
    end
    drain();
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (valid_out === 1'b1) begin
      pulses++;
      last_out = data_out;
      if (nout < 64) outs[nout] = data_out;
      nout++;
      if (sbq.size() == 0) chk("unexpected_valid_out", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("data_out", data_out, e.y);
        chk("latency", cyc, e.cyc + N + 1);
      end
    end
  end

  initial begin
    vec_t vt [6];
    int p0;
    bit done;
    vt[0] = '{"sat_pos", 16384, 16384, 32767, 32767};
    vt[1] = '{"sat_neg", 16384, 16384, -32768, -32768};
    vt[2] = '{"round_16384", 1, 0, 16384, 1};
    vt[3] = '{"round_16383", 1, 0, 16383, 0};
    vt[4] = '{"round_m16384", 1, 0, -16384, 0};
    vt[5] = '{"round_m16385", 1, 0, -16385, -1};
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    reset = 0;
    @(negedge clk);

    for (int k = 0; k < N; k++) wr_coef(k, 1024 * (k + 1));
    impulse(9);
    for (int i = 0; i < 16; i++) chk($sformatf("impulse_out%0d", i), outs[i], i < 8 ? 2 * (i + 1) : 0);
    chk("impulse_count", nout, 16);
    chk("no_overrun_at_rate", overrun, 0);

    for (int v = 0; v < 6; v++) begin
      wr_coef(0, vt[v].c0);
      for (int k = 1; k < N; k++) wr_coef(k, vt[v].crest);
      for (int i = 0; i < 20; i++) begin
        send(vt[v].x, 0);
        repeat (9) @(negedge clk);
      end
      drain();
      chk(vt[v].name, last_out, vt[v].exp_y);
    end

    p0 = pulses;
    for (int i = 0; i < 40; i++) send(i * 100, 0);
    drain();
    chk("overrun_set", overrun, 1);
    chk("overrun_few_pulses", (pulses - p0) < 20, 1);
    overrun_clr = 1;
    @(negedge clk);
    overrun_clr = 0;
    chk("overrun_cleared", overrun, 0);
    done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      bit drop;
      drop = (ph == M - 1) && (cyc + 1 - la < N + 2);
      send(i * 7 - 20, drop);
      done = drop;
    end
    chk("overrun_set_wins", overrun, 1);
    drain();

    wr_coef(0, 16384);
    for (int k = 1; k < N; k++) wr_coef(k, 0);
    for (int i = 0; i < 18; i++) begin
      send(1000, 0);
      repeat (9) @(negedge clk);
    end
    drain();
    if (ph != M - 1) begin
      send(1000, 0);
      repeat (9) @(negedge clk);
      drain();
    end
    cm[15] = 16384;
    send(1000, 0);
    @(negedge clk);
    @(negedge clk);
    coef_wr = 1;
    coef_addr = 4'd15;
    coef_data = 16'sd16384;
    @(negedge clk);
    coef_wr = 0;
    drain();
    chk("coef_mid_mac", last_out, 1000);

    if (ph != M - 1) begin
      send(500, 0);
      repeat (9) @(negedge clk);
      drain();
    end
    p0 = pulses;
    send(500, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    model_reset();
    @(negedge clk);
    chk("reset_mid_busy", busy, 0);
    @(negedge clk);
    reset = 0;
    repeat (30) @(negedge clk);
    chk("reset_mid_no_pulse", pulses - p0, 0);
    chk("reset_mid_busy_after", busy, 0);
    impulse(9);
    for (int i = 0; i < 4; i++) chk($sformatf("post_reset_zero%0d", i), outs[i], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
